ice40_ebr_ram: RTL and testbench

- Behavioural, synthesizable model of one iCE40 4-kbit embedded block RAM (EBR) used as a simple dual-port RAM: one write port and one read port.
- Used as the storage primitive under cache tag/data RAM wrappers.
- Supports the four native geometries and a per-bit write mask.
- Optionally commits writes on the falling clock edge, so a read on the next rising edge sees the new data.

---
 rtl/ice40_ebr_ram.sv | 101 ++++++++++
 tb/tb_ice40_ebr_ram.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ice40_ebr_ram.sv
// ice40_ebr_ram
// Behavioural model of one iCE40 4-kbit embedded block RAM used as a simple
// dual-port RAM: one write port, one registered read port, single clock.
//
// Storage is a flat 4096-bit vector. A word at address A in geometry M
// occupies bits [A*(16>>M) +: (16>>M)], so the read and write ports may use
// different geometries and still see a consistent view of the same bits.
//
// Parameters
//   READ_MODE        read geometry: 0=256x16, 1=512x8, 2=1024x4, 3=2048x2
//   WRITE_MODE       write geometry, same encoding as READ_MODE
//   MASK_WORKAROUND  1: wr_mask honoured in every write geometry
//                    0: wr_mask honoured only in 256x16, ignored otherwise
//   NEG_WR_CLK       1: writes commit on the falling clock edge
//                    0: writes commit on the rising clock edge
//
// Ports
//   clk      single clock for both ports
//   rst_n    asynchronous active-low reset (clears rd_data, not the array)
//   wr_addr  write word address              (8+WRITE_MODE bits)
//   wr_data  write data                      (16>>WRITE_MODE bits)
//   wr_mask  per-bit mask, 1 = keep old bit  (16>>WRITE_MODE bits)
//   wr_ena   write enable
//   rd_addr  read word address               (8+READ_MODE bits)
//   rd_ena   read enable
//   rd_data  registered read data, 1-cycle latency (16>>READ_MODE bits)

module ice40_ebr_ram #(
  parameter int unsigned READ_MODE       = 0,
  parameter int unsigned WRITE_MODE      = 0,
  parameter int unsigned MASK_WORKAROUND = 1,
  parameter int unsigned NEG_WR_CLK      = 1,
  // Derived geometry; not meant to be overridden.
  localparam int unsigned RD_AW = 8 + READ_MODE,
  localparam int unsigned RD_DW = 16 >> READ_MODE,
  localparam int unsigned WR_AW = 8 + WRITE_MODE,
  localparam int unsigned WR_DW = 16 >> WRITE_MODE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WR_AW-1:0] wr_addr,
  input  logic [WR_DW-1:0] wr_data,
  input  logic [WR_DW-1:0] wr_mask,
  input  logic             wr_ena,
  input  logic [RD_AW-1:0] rd_addr,
  input  logic             rd_ena,
  output logic [RD_DW-1:0] rd_data
);

  localparam int unsigned MemBits = 4096;
  localparam int unsigned BitAw   = 12;

  // The native primitive only applies the mask in 256x16 write mode.
  localparam bit MaskHonoured = (MASK_WORKAROUND != 0) || (WRITE_MODE == 0);

  // Array powers up as all zeros and is never cleared by reset.
  logic [MemBits-1:0] mem_q = '0;

  // Word base bit index: address scaled by the word width (a power of two).
  logic [BitAw-1:0] wr_base;
  logic [BitAw-1:0] rd_base;

  assign wr_base = BitAw'(wr_addr) << (4 - WRITE_MODE);
  assign rd_base = BitAw'(rd_addr) << (4 - READ_MODE);

  logic [WR_DW-1:0] eff_mask;
  logic [WR_DW-1:0] wr_word;

  assign eff_mask = MaskHonoured ? wr_mask : '0;
  // Merge new data into the current word: masked bits keep their old value.
  assign wr_word  = (mem_q[wr_base +: WR_DW] & eff_mask) | (wr_data & ~eff_mask);

  // rst_n appears in the sensitivity list only so that it is treated as an
  // asynchronous net everywhere; its edge itself never changes the array.
  // A write is committed only if rst_n is high at the write edge, so a reset
  // pulse overlapping a falling edge drops the pending write.
  if (NEG_WR_CLK != 0) begin : g_wr_neg
    always_ff @(negedge clk or negedge rst_n) begin
      if (rst_n && wr_ena) begin
        mem_q[wr_base +: WR_DW] <= wr_word;
      end
    end
  end else begin : g_wr_pos
    // Shares the rising edge with the read port; non-blocking update gives
    // read-before-write on a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
      if (rst_n && wr_ena) begin
        mem_q[wr_base +: WR_DW] <= wr_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_ena) begin
      rd_data <= mem_q[rd_base +: RD_DW];
    end
  end

endmodule

// File: tb/tb_ice40_ebr_ram.sv
// Self-checking bench for ice40_ebr_ram. Four instances run side by side:
//   0: 256x16 / 256x16, mask honoured, rising-edge write
//   1: 256x16 / 256x16, mask honoured, falling-edge write
//   2: write 512x8, read 256x16, mask honoured, falling-edge write
//   3: write 2048x2, read 1024x4, mask ignored, rising-edge write
// A bit-level reference model per instance predicts every read.

module tb_ice40_ebr_ram;

  localparam int WMODE [4] = '{0, 0, 1, 3};
  localparam int RMODE [4] = '{0, 0, 0, 2};
  localparam int NEGWR [4] = '{0, 1, 1, 0};
  localparam int MASKW [4] = '{1, 1, 1, 0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] wa [4];
  logic [15:0] wd [4];
  logic [15:0] wm [4];
  logic        we [4];
  logic [11:0] ra [4];
  logic        re [4];

  logic [15:0] rd_a;
  logic [15:0] rd_b;
  logic [15:0] rd_c;
  logic [3:0]  rd_d;

  int checks = 0;
  int failures = 0;

  bit   [4095:0] ref_mem [4];
  logic [15:0]   exp_rd  [4];

  always #5 clk = ~clk;

  ice40_ebr_ram #(.READ_MODE(0), .WRITE_MODE(0), .MASK_WORKAROUND(1), .NEG_WR_CLK(0)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_addr(wa[0][7:0]), .wr_data(wd[0]), .wr_mask(wm[0]),
    .wr_ena(we[0]), .rd_addr(ra[0][7:0]), .rd_ena(re[0]), .rd_data(rd_a)
  );
  ice40_ebr_ram #(.READ_MODE(0), .WRITE_MODE(0), .MASK_WORKAROUND(1), .NEG_WR_CLK(1)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_addr(wa[1][7:0]), .wr_data(wd[1]), .wr_mask(wm[1]),
    .wr_ena(we[1]), .rd_addr(ra[1][7:0]), .rd_ena(re[1]), .rd_data(rd_b)
  );
  ice40_ebr_ram #(.READ_MODE(0), .WRITE_MODE(1), .MASK_WORKAROUND(1), .NEG_WR_CLK(1)) u_c (
    .clk(clk), .rst_n(rst_n), .wr_addr(wa[2][8:0]), .wr_data(wd[2][7:0]), .wr_mask(wm[2][7:0]),
    .wr_ena(we[2]), .rd_addr(ra[2][7:0]), .rd_ena(re[2]), .rd_data(rd_c)
  );
  ice40_ebr_ram #(.READ_MODE(2), .WRITE_MODE(3), .MASK_WORKAROUND(0), .NEG_WR_CLK(0)) u_d (
    .clk(clk), .rst_n(rst_n), .wr_addr(wa[3][10:0]), .wr_data(wd[3][1:0]), .wr_mask(wm[3][1:0]),
    .wr_ena(we[3]), .rd_addr(ra[3][9:0]), .rd_ena(re[3]), .rd_data(rd_d)
  );

  function automatic logic [15:0] obs(input int k);
    case (k)
      0:       return rd_a;
      1:       return rd_b;
      2:       return rd_c;
      default: return {12'h000, rd_d};
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] o, input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Reference model: word A in mode M is bits A*(16>>M) .. A*(16>>M)+(16>>M)-1.
  task automatic model_write(input int k);
    int w;
    bit mbit;
    w = 16 >> WMODE[k];
    if (!we[k]) return;
    for (int i = 0; i < w; i++) begin
      mbit = (MASKW[k] == 0 && WMODE[k] != 0) ? 1'b0 : wm[k][i];
      if (!mbit) ref_mem[k][int'(wa[k]) * w + i] = wd[k][i];
    end
  endtask

  task automatic model_read(input int k);
    int w;
    w = 16 >> RMODE[k];
    if (!re[k]) return;
    exp_rd[k] = '0;
    for (int i = 0; i < w; i++) exp_rd[k][i] = ref_mem[k][int'(ra[k]) * w + i];
  endtask

  // One clock with the inputs currently applied; checks every instance.
  task automatic tick(input string tag);
    for (int k = 0; k < 4; k++) begin
      if (NEGWR[k] != 0) begin
        model_write(k);
        model_read(k);
      end else begin
        model_read(k);
        model_write(k);
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) check($sformatf("%s/dut%0d", tag, k), obs(k), exp_rd[k]);
  endtask

  task automatic idle();
    for (int k = 0; k < 4; k++) begin
      we[k] = 1'b0;
      re[k] = 1'b0;
    end
  endtask

  task automatic wr(input int k, input int addr, input logic [15:0] data, input logic [15:0] mask);
    we[k] = 1'b1;
    wa[k] = 12'(addr);
    wd[k] = data;
    wm[k] = mask;
  endtask

  task automatic rd(input int k, input int addr);
    re[k] = 1'b1;
    ra[k] = 12'(addr);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      wa[k] = '0; wd[k] = '0; wm[k] = '0; ra[k] = '0;
      ref_mem[k] = '0;
      exp_rd[k] = '0;
    end
    idle();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) check($sformatf("reset/dut%0d", k), obs(k), 16'h0000);
    rst_n = 1'b1;

    // Basic writes; geometry mixing on instances 2 and 3.
    idle(); wr(0, 'h12, 16'hA5C3, 16'h0000); wr(2, 0, 16'h0034, 16'h0000);
    wr(3, 0, 16'h0003, 16'h0003);
    tick("t1");

    idle(); rd(0, 'h12); wr(2, 1, 16'h0012, 16'h0000); rd(2, 0);
    wr(3, 1, 16'h0002, 16'h0003); rd(3, 0);
    tick("t2");
    check("basic_rd", rd_a, 16'hA5C3);
    check("mix_w1_r0", rd_c, 16'h1234);
    check("w3_mask_ignored_rbw", obs(3), 16'h0003);

    // Same-cycle read/write of one address: old data on rising-edge write,
    // new data on falling-edge write.
    idle(); wr(0, 7, 16'h1234, 16'h0000); rd(0, 7); wr(1, 7, 16'h1234, 16'h0000); rd(1, 7);
    wr(2, 1, 16'h0000, 16'h00F0); rd(2, 0); rd(3, 0);
    tick("t3");
    check("rbw_pos", rd_a, 16'h0000);
    check("fwd_neg", rd_b, 16'h1234);
    check("mix_masked", rd_c, 16'h1034);
    check("w3_second", obs(3), 16'h000B);

    idle(); rd(0, 7); wr(0, 5, 16'hFFFF, 16'h0000);
    tick("t4");
    check("after_pos_wr", rd_a, 16'h1234);

    idle(); rd(0, 'h33); wr(0, 5, 16'h0000, 16'hFF00);
    tick("t5");
    check("unwritten", rd_a, 16'h0000);

    idle(); rd(0, 5); wr(0, 5, 16'h1234, 16'hFFFF);
    tick("t6");
    check("mask_ff00", rd_a, 16'hFF00);

    idle(); rd(0, 5); wr(0, 3, 16'h00AA, 16'h0000);
    tick("t7");
    check("mask_ffff", rd_a, 16'hFF00);

    idle(); rd(0, 3);
    tick("t8");
    check("rd_addr3", rd_a, 16'h00AA);

    idle(); ra[0] = 12'h012;
    tick("t9");
    check("rd_hold", rd_a, 16'h00AA);

    // Asynchronous reset pulse mid-cycle, spanning a falling and a rising
    // edge, with writes and reads requested throughout.
    #1;
    rst_n = 1'b0;
    wr(0, 'h12, 16'hDEAD, 16'h0000); rd(0, 'h12);
    wr(1, 7, 16'hBEEF, 16'h0000);
    wr(2, 0, 16'h0055, 16'h0000);
    wr(3, 0, 16'h0000, 16'h0000);
    #1;
    for (int k = 0; k < 4; k++) check($sformatf("async_rst/dut%0d", k), obs(k), 16'h0000);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("in_rst/dut%0d", k), obs(k), 16'h0000);
      exp_rd[k] = '0;
    end
    idle();
    rst_n = 1'b1;

    idle(); rd(0, 'h12); rd(1, 7); rd(2, 0); rd(3, 0);
    tick("t10");
    check("kept_a", rd_a, 16'hA5C3);
    check("kept_b", rd_b, 16'h1234);
    check("kept_c", rd_c, 16'h1034);
    check("kept_d", obs(3), 16'h000B);

    // Randomized traffic; small address windows make collisions frequent.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 4; k++) begin
        int wmax;
        int rmax;
        wmax = (256 << WMODE[k]) - 1;
        rmax = (256 << RMODE[k]) - 1;
        we[k] = 1'($urandom_range(0, 1));
        re[k] = 1'($urandom_range(0, 3) != 0);
        wa[k] = 12'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, wmax));
        ra[k] = 12'(($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, rmax));
        wd[k] = 16'($urandom) & 16'((32'h1 << (16 >> WMODE[k])) - 1);
        wm[k] = ($urandom_range(0, 1) != 0) ? 16'h0000 : 16'($urandom);
      end
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
